// File: rtl/explosion_scheduler_pkg.sv
// Shared types and sizing for the explosion scheduler.
// The optional pending buffer in the top level is enabled by defining EXPL_PENDING_EN.
package explosion_pkg;

    localparam int NUM_REQ    = 4;
    localparam int NUM_SLOTS  = 4;
    localparam int NUM_FRAMES = 8;
    localparam int FRAME_HOLD = 4;
    localparam int SPR_LOG2   = 5;

    localparam int SPR_EDGE = 2 ** SPR_LOG2;
    localparam int FRAME_W  = $clog2(NUM_FRAMES);
    localparam int SUB_W    = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam int ADDR_W   = FRAME_W + 2 * SPR_LOG2;
    localparam int CNT_W    = $clog2(NUM_SLOTS) + 1;

    typedef enum logic {
        SLOT_IDLE   = 1'b0,
        SLOT_ACTIVE = 1'b1
    } slot_state_e;

    typedef struct packed {
        slot_state_e        active;
        logic [9:0]         x;
        logic [9:0]         y;
        logic [FRAME_W-1:0] frame;
        logic [SUB_W-1:0]   sub;
    } slot_t;

    // Sprite ROM address layout: {frame, dy, dx}.
    function automatic logic [ADDR_W-1:0] pack_addr(
        input logic [FRAME_W-1:0]  frame,
        input logic [SPR_LOG2-1:0] dy,
        input logic [SPR_LOG2-1:0] dx
    );
        return {frame, dy, dx};
    endfunction

endpackage

// File: rtl/explosion_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at the pointer,
// pointer moves to the slot after the winner.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Scan farthest offset first so the nearest requester from the pointer wins.
    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        if (enable) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (req[(int'(ptr_q) + k) % NUM_REQ]) begin
                    grant = '0;
                    grant[(int'(ptr_q) + k) % NUM_REQ] = 1'b1;
                    ptr_d = PTR_W'((int'(ptr_q) + k + 1) % NUM_REQ);
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/explosion_scheduler.sv
// Explosion slot allocator, animation sequencer and per-pixel sprite lookup.
// Define EXPL_PENDING_EN to add a one-entry buffer instead of dropping requests when all slots are busy.
module explosion_scheduler
    import explosion_pkg::*;
(
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     frame_start,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0][9:0]  req_x,
    input  logic [NUM_REQ-1:0][9:0]  req_y,
    output logic [NUM_REQ-1:0]       ack,
    output logic                     drop,
    input  logic [9:0]               DrawX,
    input  logic [9:0]               DrawY,
    output logic                     expl_hit,
    output logic [ADDR_W-1:0]        expl_addr,
    output logic [CNT_W-1:0]         active_cnt
);
    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    slot_t                       slot_q [NUM_SLOTS];
    slot_t                       slot_d [NUM_SLOTS];
    logic [NUM_REQ-1:0]          ack_q, ack_d;
    logic                        drop_q, drop_d;
    logic                        hit_q, hit_d;
    logic [ADDR_W-1:0]           addr_q, addr_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [NUM_REQ-1:0]          grant, arb_req;
    logic                        arb_en, free_any, alloc_v;
    logic [SLOT_W-1:0]           free_idx;
    logic [9:0]                  gnt_x, gnt_y, alloc_x, alloc_y;
    logic [NUM_SLOTS-1:0][9:0]   dx, dy;
    logic [NUM_SLOTS-1:0]        slot_hit;

`ifdef EXPL_PENDING_EN
    logic       pend_v_q, pend_v_d;
    logic [9:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    assign arb_en = ~pend_v_q;
`else
    assign arb_en = 1'b1;
`endif

    // A requester still sees its ack this cycle and has not yet dropped req.
    assign arb_req = req & ~ack_q;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .req     (arb_req),
        .enable  (arb_en),
        .grant   (grant)
    );

    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
            if (slot_q[s].active == SLOT_IDLE) begin
                free_any = 1'b1;
                free_idx = SLOT_W'(s);
            end
        end
        gnt_x = '0;
        gnt_y = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gnt_x = req_x[i];
                gnt_y = req_y[i];
            end
        end
    end

    always_comb begin
        ack_d   = grant;
        drop_d  = 1'b0;
        alloc_v = 1'b0;
        alloc_x = gnt_x;
        alloc_y = gnt_y;
`ifdef EXPL_PENDING_EN
        pend_v_d = pend_v_q;
        pend_x_d = pend_x_q;
        pend_y_d = pend_y_q;
        if (pend_v_q && free_any) begin
            alloc_v  = 1'b1;
            alloc_x  = pend_x_q;
            alloc_y  = pend_y_q;
            pend_v_d = 1'b0;
        end else if ((|grant) && free_any) begin
            alloc_v = 1'b1;
        end else if (|grant) begin
            pend_v_d = 1'b1;
            pend_x_d = gnt_x;
            pend_y_d = gnt_y;
        end
`else
        alloc_v = (|grant) && free_any;
        drop_d  = (|grant) && !free_any;
`endif
        for (int s = 0; s < NUM_SLOTS; s++) begin
            slot_d[s] = slot_q[s];
            if (frame_start && slot_q[s].active == SLOT_ACTIVE) begin
                if (slot_q[s].sub == SUB_W'(FRAME_HOLD - 1)) begin
                    slot_d[s].sub = '0;
                    if (slot_q[s].frame == FRAME_W'(NUM_FRAMES - 1)) begin
                        slot_d[s].active = SLOT_IDLE;
                    end else begin
                        slot_d[s].frame = slot_q[s].frame + 1'b1;
                    end
                end else begin
                    slot_d[s].sub = slot_q[s].sub + 1'b1;
                end
            end
        end
        // The chosen slot was idle, so the frame_start update above never touches it.
        if (alloc_v) begin
            slot_d[free_idx] = '{active: SLOT_ACTIVE, x: alloc_x, y: alloc_y, frame: '0, sub: '0};
        end
    end

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_cmp
        assign dx[gi]       = DrawX - slot_q[gi].x;
        assign dy[gi]       = DrawY - slot_q[gi].y;
        assign slot_hit[gi] = (slot_q[gi].active == SLOT_ACTIVE) &&
                              (dx[gi] < 10'(SPR_EDGE)) && (dy[gi] < 10'(SPR_EDGE));
    end

    always_comb begin
        hit_d  = 1'b0;
        addr_d = '0;
        for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
            if (slot_hit[s]) begin
                hit_d  = 1'b1;
                addr_d = pack_addr(slot_q[s].frame, dy[s][SPR_LOG2-1:0], dx[s][SPR_LOG2-1:0]);
            end
        end
    end

    always_comb begin
        cnt_d = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            cnt_d = cnt_d + CNT_W'(slot_d[s].active == SLOT_ACTIVE);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                slot_q[s] <= '0;
            end
            ack_q  <= '0;
            drop_q <= 1'b0;
            hit_q  <= 1'b0;
            addr_q <= '0;
            cnt_q  <= '0;
`ifdef EXPL_PENDING_EN
            pend_v_q <= 1'b0;
            pend_x_q <= '0;
            pend_y_q <= '0;
`endif
        end else begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                slot_q[s] <= slot_d[s];
            end
            ack_q  <= ack_d;
            drop_q <= drop_d;
            hit_q  <= hit_d;
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
`ifdef EXPL_PENDING_EN
            pend_v_q <= pend_v_d;
            pend_x_q <= pend_x_d;
            pend_y_q <= pend_y_d;
`endif
        end
    end

    assign ack        = ack_q;
    assign drop       = drop_q;
    assign expl_hit   = hit_q;
    assign expl_addr  = addr_q;
    assign active_cnt = cnt_q;

endmodule

// File: tb/tb_explosion_scheduler.sv
// Scoreboard bench: a pulse-count reference model predicts acks and pixel results,
// a monitor on the falling edge compares them against the DUT.
`timescale 1ns/1ps
module tb_explosion_scheduler;
    import explosion_pkg::*;

    logic                    Clk = 1'b0;
    logic                    Reset_n = 1'b0;
    logic                    frame_start = 1'b0;
    logic [NUM_REQ-1:0]      req = '0;
    logic [NUM_REQ-1:0][9:0] req_x;
    logic [NUM_REQ-1:0][9:0] req_y;
    logic [NUM_REQ-1:0]      ack;
    logic                    drop;
    logic [9:0]              DrawX = '0;
    logic [9:0]              DrawY = '0;
    logic                    expl_hit;
    logic [ADDR_W-1:0]       expl_addr;
    logic [CNT_W-1:0]        active_cnt;

    explosion_scheduler dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_start (frame_start),
        .req         (req),
        .req_x       (req_x),
        .req_y       (req_y),
        .ack         (ack),
        .drop        (drop),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .expl_hit    (expl_hit),
        .expl_addr   (expl_addr),
        .active_cnt  (active_cnt)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int                 cyc;
        logic [NUM_REQ-1:0] ack;
        logic               drop;
    } ack_exp_t;

    typedef struct {
        logic              hit;
        logic [ADDR_W-1:0] addr;
        int                cnt;
    } pix_exp_t;

    ack_exp_t exp_ack_q[$];
    pix_exp_t exp_pix_q[$];
    int       got_order[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit run   = 1'b0;

    // Reference state: an explosion is just a position and a count of pulses seen.
    bit                 m_act [NUM_SLOTS];
    int                 m_x   [NUM_SLOTS];
    int                 m_y   [NUM_SLOTS];
    int                 m_age [NUM_SLOTS];
    int                 m_ptr = 0;
    logic [NUM_REQ-1:0] m_lastack = '0;
    bit                 m_pv = 1'b0;
    int                 m_px = 0;
    int                 m_py = 0;
    int                 hx [NUM_REQ];
    int                 hy [NUM_REQ];

    function automatic bit m_busy();
        for (int s = 0; s < NUM_SLOTS; s++) if (m_act[s]) return 1'b1;
        return m_pv;
    endfunction

    task automatic place(input int f, input int x, input int y);
        m_act[f] = 1'b1;
        m_x[f]   = x;
        m_y[f]   = y;
        m_age[f] = 0;
    endtask

    task automatic model_step();
        pix_exp_t           pe;
        ack_exp_t           ae;
        int                 f, g, dxs, dys, n, idx;
        logic [NUM_REQ-1:0] eff;
        bit                 en, dr;
        pe.hit  = 1'b0;
        pe.addr = '0;
        for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
            if (m_act[s]) begin
                dxs = (int'(DrawX) - m_x[s]) & 1023;
                dys = (int'(DrawY) - m_y[s]) & 1023;
                if (dxs < SPR_EDGE && dys < SPR_EDGE) begin
                    pe.hit  = 1'b1;
                    pe.addr = ADDR_W'(((m_age[s] / FRAME_HOLD) << (2 * SPR_LOG2)) | (dys << SPR_LOG2) | dxs);
                end
            end
        end
        f = -1;
        for (int s = NUM_SLOTS - 1; s >= 0; s--) if (!m_act[s]) f = s;
        eff = req & ~m_lastack;
`ifdef EXPL_PENDING_EN
        en = !m_pv;
`else
        en = 1'b1;
`endif
        g = -1;
        if (en) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (m_ptr + k) % NUM_REQ;
                if (g < 0 && eff[idx]) g = idx;
            end
        end
        if (g >= 0) m_ptr = (g + 1) % NUM_REQ;
        if (frame_start) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (m_act[s]) begin
                    m_age[s]++;
                    if (m_age[s] == NUM_FRAMES * FRAME_HOLD) m_act[s] = 1'b0;
                end
            end
        end
        dr = 1'b0;
`ifdef EXPL_PENDING_EN
        if (m_pv && f >= 0) begin
            place(f, m_px, m_py);
            m_pv = 1'b0;
        end else if (g >= 0 && f >= 0) begin
            place(f, int'(req_x[g]), int'(req_y[g]));
        end else if (g >= 0) begin
            m_pv = 1'b1;
            m_px = int'(req_x[g]);
            m_py = int'(req_y[g]);
        end
`else
        if (g >= 0 && f >= 0) place(f, int'(req_x[g]), int'(req_y[g]));
        else if (g >= 0) dr = 1'b1;
`endif
        cyc++;
        m_lastack = '0;
        if (g >= 0) begin
            m_lastack[g] = 1'b1;
            ae.cyc  = cyc;
            ae.ack  = m_lastack;
            ae.drop = dr;
            exp_ack_q.push_back(ae);
        end
        n = 0;
        for (int s = 0; s < NUM_SLOTS; s++) if (m_act[s]) n++;
        pe.cnt = n;
        exp_pix_q.push_back(pe);
    endtask

    initial begin
        wait (run);
        forever begin
            @(posedge Clk);
            if (!run) break;
            model_step();
        end
    end

    task automatic check_cycle();
        ack_exp_t ae;
        pix_exp_t pe;
        if (ack != '0 || drop) begin
            total++;
            if (exp_ack_q.size() == 0) begin
                bad++;
                $display("FAIL ack_unexpected: got ack=%b drop=%b at cyc %0d, want no grant", ack, drop, cyc);
            end else begin
                ae = exp_ack_q.pop_front();
                if (ae.cyc != cyc || ae.ack !== ack || ae.drop !== drop) begin
                    bad++;
                    $display("FAIL ack: got ack=%b drop=%b cyc=%0d, want ack=%b drop=%b cyc=%0d",
                             ack, drop, cyc, ae.ack, ae.drop, ae.cyc);
                end else begin
                    $display("grant cyc=%0d ack=%b drop=%b active_cnt=%0d", cyc, ack, drop, active_cnt);
                end
            end
        end
        while (exp_ack_q.size() > 0 && exp_ack_q[0].cyc <= cyc) begin
            ae = exp_ack_q.pop_front();
            total++;
            bad++;
            $display("FAIL ack_missing: got ack=%b drop=%b, want ack=%b drop=%b at cyc %0d",
                     ack, drop, ae.ack, ae.drop, ae.cyc);
        end
        if (exp_pix_q.size() == 0) pe = '{hit: 1'b0, addr: '0, cnt: 0};
        else pe = exp_pix_q.pop_front();
        total++;
        if (expl_hit !== pe.hit || expl_addr !== pe.addr || int'(active_cnt) != pe.cnt) begin
            bad++;
            $display("FAIL pixel: cyc=%0d got hit=%b addr=%h cnt=%0d, want hit=%b addr=%h cnt=%0d",
                     cyc, expl_hit, expl_addr, active_cnt, pe.hit, pe.addr, pe.cnt);
        end
    endtask

    initial begin
        forever begin
            @(negedge Clk);
            if (run) check_cycle();
        end
    end

    task automatic tick(input bit fs, input int nx, input int ny);
        @(negedge Clk);
        for (int i = 0; i < NUM_REQ; i++) if (ack[i]) got_order.push_back(i);
        req         = req & ~ack;
        frame_start = fs;
        DrawX       = 10'(nx & 1023);
        DrawY       = 10'(ny & 1023);
    endtask

    task automatic issue(input int i, input int x, input int y);
        req_x[i] = 10'(x);
        req_y[i] = 10'(y);
        req[i]   = 1'b1;
        hx[i]    = x;
        hy[i]    = y;
    endtask

    task automatic wait_req_clear(input int budget, input bit pulses);
        int c;
        c = 0;
        while (req != '0 && c < budget) begin
            tick(pulses && (c % 2 == 0), int'(DrawX), int'(DrawY));
            c++;
        end
        total++;
        if (req != '0) begin
            bad++;
            $display("FAIL req_timeout: req=%b after %0d cycles, want 0", req, budget);
        end
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((m_busy() || req != '0) && c < 1000) begin
            tick(c % 2 == 0, int'(DrawX), int'(DrawY));
            c++;
        end
        tick(1'b0, 0, 0);
        total++;
        if (m_busy() || req != '0) begin
            bad++;
            $display("FAIL drain_timeout: req=%b active_cnt=%0d, want idle", req, active_cnt);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, j;
        req_x = '0;
        req_y = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hx[i] = 0;
            hy[i] = 0;
        end
        repeat (3) @(negedge Clk);
        total++;
        if (expl_hit !== 1'b0 || active_cnt !== '0 || ack !== '0 || drop !== 1'b0 || expl_addr !== '0) begin
            bad++;
            $display("FAIL reset_state: got hit=%b cnt=%0d ack=%b drop=%b addr=%h, want all 0",
                     expl_hit, active_cnt, ack, drop, expl_addr);
        end
        Reset_n = 1'b1;
        run     = 1'b1;

        // All four request at once with every slot free: grants in order 0,1,2,3.
        got_order.delete();
        for (int i = 0; i < NUM_REQ; i++) issue(i, 200 + 40 * i, 100 + 30 * i);
        wait_req_clear(20, 1'b0);
        total++;
        if (got_order.size() != 4 || got_order[0] != 0 || got_order[1] != 1 ||
            got_order[2] != 2 || got_order[3] != 3) begin
            bad++;
            $display("FAIL grant_order: got %p, want 0 1 2 3", got_order);
        end
        // Slots are full: drop (or buffer) behaviour.
        for (int i = 0; i < NUM_REQ; i++) issue(i, 600 + 20 * i, 300);
        wait_req_clear(600, 1'b1);
        drain();

        // Single explosion at (100,50): corner hits, edge miss.
        issue(0, 100, 50);
        wait_req_clear(20, 1'b0);
        tick(1'b0, 100, 50);
        tick(1'b0, 131, 81);
        tick(1'b0, 132, 50);
        tick(1'b0, 100, 82);
        tick(1'b0, 99, 50);
        // Animation: frame steps every FRAME_HOLD pulses, retire after the last.
        for (int p = 0; p < NUM_FRAMES * FRAME_HOLD + 2; p++) begin
            tick(1'b1, 100 + p, 50 + p);
            tick(1'b0, 100, 50);
        end
        drain();

        // Overlap: the lower-index slot wins the pixel.
        issue(0, 100, 50);
        wait_req_clear(20, 1'b0);
        issue(1, 110, 60);
        wait_req_clear(20, 1'b0);
        tick(1'b0, 115, 65);
        tick(1'b0, 135, 85);
        tick(1'b0, 141, 91);
        tick(1'b0, 1023, 1023);
        drain();

        // Randomized traffic, including positions that wrap the 10-bit coordinate.
        for (int c = 0; c < 2500; c++) begin
            j = int'($urandom_range(0, NUM_REQ - 1));
            tick($urandom_range(0, 2) == 0,
                 hx[j] + int'($urandom_range(0, 40)) - 4,
                 hy[j] + int'($urandom_range(0, 40)) - 4);
            if ($urandom_range(0, 3) == 0) begin
                r = int'($urandom_range(0, NUM_REQ - 1));
                if (!req[r]) issue(r, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
            end
        end

        // Asynchronous reset with explosions in flight.
        if (!req[2]) issue(2, 300, 200);
        tick(1'b0, 300, 200);
        tick(1'b0, 300, 200);
        tick(1'b0, 300, 200);
        #1 run = 1'b0;
        #2 Reset_n = 1'b0;
        #1;
        total++;
        if (expl_hit !== 1'b0 || active_cnt !== '0 || ack !== '0 || drop !== 1'b0 || expl_addr !== '0) begin
            bad++;
            $display("FAIL async_reset: got hit=%b cnt=%0d ack=%b drop=%b addr=%h, want all 0",
                     expl_hit, active_cnt, ack, drop, expl_addr);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
